ahb_decode_mux: RTL
===================

Name: ahb_decode_mux

Overview:
Parametrised AHB-Lite address decoder and slave-to-master response multiplexer for the SoC bus. It supports a configurable number of slaves, each with a base/mask address window. Address-phase decode drives the one-hot HSEL outputs; the data-phase slave index is registered so that HRDATA, HREADY and HRESP come from the slave owning the current data phase. Unmapped transfers are absorbed by a built-in default slave, which returns the two-cycle AHB ERROR response and counts decode errors.

Parameters:
NSLV, 4, number of slaves (1..16); slave 0 = SRAM, 1 = UART, 2 = interrupt_reg, 3 = spare
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {32'h40003000, 32'h40002000, 32'h4000D000, 32'h00000000}, packed NSLV*ADDR_W base addresses; slave i occupies bits [i*ADDR_W +: ADDR_W]
SLV_MASK, {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000}, packed per-slave masks; slave i matches when (HADDR & MASK_i) == (BASE_i & MASK_i)
CNT_W, 16, width of the decode-error counter

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
HADDR  in  ADDR_W  master address
HTRANS  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
HSEL  out  NSLV  one-hot slave select (combinational)
HRDATA_S  in  NSLV*DATA_W  slave read data, packed
HREADYOUT_S  in  NSLV  per-slave ready
HRESP_S  in  NSLV*2  per-slave response (0 OKAY, 1 ERROR)
HRDATA  out  DATA_W  read data to master
HREADY  out  1  combined ready to master and all slaves
HRESP  out  2  response to master
DECERR_CNT  out  CNT_W  count of unmapped active transfers
DECERR_CLR  in  1  synchronous clear of DECERR_CNT

Behaviour:
- Decode is combinational on HADDR only.
  - HSEL[i] = match_i AND no match_j for any j<i; the lowest index wins when windows overlap.
  - At most one HSEL bit is high; all bits are 0 when unmapped.
  - HSEL does not depend on HTRANS; slaves qualify with HTRANS and HREADY.
- Data-phase register dsel: NSLV+1 encodings, one per slave plus DEF.
  - Loads only when HREADY=1, from the winning index (or DEF if unmapped).
  - Holds while HREADY=0.
- Default-slave FSM states: D_OK, D_ERR1, D_ERR2.
  - D_OK -> D_ERR1 when HREADY=1, the address is unmapped, and HTRANS is NONSEQ or SEQ.
  - D_ERR1 -> D_ERR2 unconditionally.
  - D_ERR2 -> D_ERR1 on another unmapped NONSEQ/SEQ; otherwise -> D_OK.
  - Unmapped IDLE/BUSY: stay in D_OK, giving a zero-wait OKAY.
- Outputs when dsel = slave i: HRDATA = HRDATA_S[i], HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i].
- Outputs when dsel = DEF:
  - HRDATA = 0.
  - D_OK: HREADY=1, HRESP=0.
  - D_ERR1: HREADY=0, HRESP=1.
  - D_ERR2: HREADY=1, HRESP=1.
- Latency: the response comes from the slave addressed one accepted address phase earlier. The block adds no wait states for mapped slaves; unmapped active transfers add exactly one wait state.
- DECERR_CNT:
  - Increments on each D_OK->D_ERR1 or D_ERR2->D_ERR1 transition.
  - Saturates at all-ones and does not wrap.
  - DECERR_CLR has priority over increment; the counter reads 0 on the next cycle.
- Reset (HRESETn=0 at posedge): dsel=DEF, FSM=D_OK, DECERR_CNT=0. Resulting outputs: HREADY=1, HRESP=0, HRDATA=0.
  - HSEL stays combinational and is unaffected by reset.
  - Reset mid-ERROR aborts the sequence; D_OK takes effect the next cycle.
- Simultaneous events:
  - A slave stalling (HREADYOUT_S=0) freezes dsel, so the address presented during the stall is not decoded into dsel.
  - An ERROR from a real slave is passed through unmodified and is not counted.
- Elaboration checks: NSLV outside 1..16, or any mask with a zero bit above a one bit (non-contiguous), is an elaboration error.

Test Plan:
- Reset, then NONSEQ read at 0x00000010 with SRAM HRDATA_S=0xDEADBEEF -> HSEL=4'b0001; next cycle HRDATA=0xDEADBEEF, HREADY=1, HRESP=0.
- NONSEQ at 0x4000D004 with UART HREADYOUT_S low for 2 cycles -> HSEL=4'b0010; HREADY=0 for 2 cycles, then 1; dsel held while 0x40002000 is presented during the stall.
- NONSEQ at 0x50000000 (unmapped) -> HSEL=0; next cycle HREADY=0/HRESP=1; following cycle HREADY=1/HRESP=1; DECERR_CNT=1.
- IDLE at 0x50000000 -> HREADY=1, HRESP=0, DECERR_CNT unchanged.
- Back-to-back unmapped NONSEQ accepted in D_ERR2 -> D_ERR2->D_ERR1, DECERR_CNT increments to 2; then DECERR_CLR with a simultaneous error -> DECERR_CNT=0.
- Overlap build with SLV_BASE[1]=SLV_BASE[0]=0 and NSLV=2 -> address 0x0 gives HSEL=2'b01; with CNT_W=2, four errors -> DECERR_CNT saturates at 3.

Source files
------------

// File: rtl/ahb_decode_mux.sv
// AHB-Lite address decoder and slave response multiplexer with a built-in
// default slave that answers unmapped transfers with a two-cycle ERROR.

module ahb_win_match #(
  parameter int                  ADDR_W = 32,
  parameter logic [ADDR_W-1:0]   BASE   = '0,
  parameter logic [ADDR_W-1:0]   MASK   = '0
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic              match
);
  assign match = ((haddr & MASK) == (BASE & MASK));
endmodule

module ahb_decode_mux #(
  parameter int NSLV   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE =
    {32'h40003000, 32'h40002000, 32'h4000D000, 32'h00000000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK =
    {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFF0000},
  parameter int CNT_W  = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic [1:0]               HTRANS,
  output logic [NSLV-1:0]          HSEL,
  input  logic [NSLV*DATA_W-1:0]   HRDATA_S,
  input  logic [NSLV-1:0]          HREADYOUT_S,
  input  logic [NSLV*2-1:0]        HRESP_S,
  output logic [DATA_W-1:0]        HRDATA,
  output logic                     HREADY,
  output logic [1:0]               HRESP,
  output logic [CNT_W-1:0]         DECERR_CNT,
  input  logic                     DECERR_CLR
);

  localparam int              SW  = $clog2(NSLV + 1);
  localparam logic [SW-1:0]   DEF = SW'(NSLV);

  typedef enum logic [1:0] {D_OK, D_ERR1, D_ERR2} dstate_e;

  // A legal mask is a run of ones followed by a run of zeros: its inverse
  // must be of the form 0..01..1.
  function automatic bit mask_ok(input logic [ADDR_W-1:0] m);
    logic [ADDR_W-1:0] inv, one;
    inv = ~m;
    one = {{(ADDR_W-1){1'b0}}, 1'b1};
    return ((inv & (inv + one)) == '0);
  endfunction

  if (NSLV < 1 || NSLV > 16) begin : g_bad_nslv
    $error("ahb_decode_mux: NSLV must be 1..16");
  end

  logic [NSLV-1:0] match;

  for (genvar i = 0; i < NSLV; i++) begin : g_win
    if (!mask_ok(SLV_MASK[i*ADDR_W +: ADDR_W])) begin : g_bad_mask
      $error("ahb_decode_mux: non-contiguous slave mask");
    end
    ahb_win_match #(
      .ADDR_W (ADDR_W),
      .BASE   (SLV_BASE[i*ADDR_W +: ADDR_W]),
      .MASK   (SLV_MASK[i*ADDR_W +: ADDR_W])
    ) u_match (
      .haddr (HADDR),
      .match (match[i])
    );
  end

  // Lowest index wins on overlapping windows.
  logic [SW-1:0] win;
  always_comb begin
    logic found;
    found = 1'b0;
    HSEL  = '0;
    win   = DEF;
    for (int i = 0; i < NSLV; i++) begin
      if (match[i] && !found) begin
        HSEL[i] = 1'b1;
        win     = SW'(i);
      end
      found = found | match[i];
    end
  end

  logic unmapped, active, err_start;
  assign unmapped  = ~|HSEL;
  assign active    = (HTRANS == 2'b10) || (HTRANS == 2'b11);
  assign err_start = HREADY && unmapped && active;

  logic [SW-1:0] dsel;
  dstate_e       state, state_nxt;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dsel  <= DEF;
      state <= D_OK;
    end else begin
      if (HREADY) dsel <= win;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      D_OK:    if (err_start) state_nxt = D_ERR1;
      D_ERR1:  state_nxt = D_ERR2;
      D_ERR2:  state_nxt = err_start ? D_ERR1 : D_OK;
      default: state_nxt = D_OK;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 2'b00;
    if (dsel == DEF) begin
      case (state)
        D_ERR1:  begin HREADY = 1'b0; HRESP = 2'b01; end
        D_ERR2:  begin HREADY = 1'b1; HRESP = 2'b01; end
        default: begin HREADY = 1'b1; HRESP = 2'b00; end
      endcase
    end else begin
      for (int i = 0; i < NSLV; i++) begin
        if (dsel == SW'(i)) begin
          HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
          HREADY = HREADYOUT_S[i];
          HRESP  = HRESP_S[i*2 +: 2];
        end
      end
    end
  end

  // Only default-slave entries into D_ERR1 count; real-slave errors do not.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || DECERR_CLR)             DECERR_CNT <= '0;
    else if (err_start && DECERR_CNT != '1) DECERR_CNT <= DECERR_CNT + CNT_W'(1);
  end

endmodule
